// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the transmit and (future) receive paths.
package uart_pkg;

  // Transmitter FSM states; encoding is visible on the 3-bit state register.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_t;

  // 50 MHz system clock / 115200 baud.
  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

  // Data bits per frame; matches the FIFO_Buffer word width.
  localparam int UART_DATA_W = 8;

endpackage : uart_pkg

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of
// each bit period. Held at zero while clear is high so the first bit after
// clear lasts exactly CLKS_PER_BIT clocks.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the bit boundary, force to zero on clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Last clock of the current bit period (suppressed while cleared).
  assign tick = !clear && (cnt_q == LAST);

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_counter

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that drains FIFO_Buffer: pops one byte per frame and
// sends it as start + DATA_W data bits (LSB first) + STOP_BITS stop bits.
//
// FIFO read contract: fifo_rd_en is a one-cycle pulse issued only in FETCH,
// which is entered only after fifo_empty was seen low; the FIFO presents the
// popped word on fifo_data in the following cycle (LOAD), where it is
// captured. Exactly one pop per frame.
//
// All outputs are registered and derived from the next state, so they line
// up with the state register and never glitch.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_W       = UART_DATA_W,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic baud_clear;
  logic baud_tick;

  // Baud timer only runs inside a frame; held clear otherwise so START
  // always begins at count zero.
  assign baud_clear = (state_q != START) && (state_q != DATA) && (state_q != STOP);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    busy_d    = 1'b0;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        state_d = LOAD;
      end

      LOAD: begin
        shift_d   = fifo_data;
        bit_cnt_d = '0;
        state_d   = START;
      end

      START: begin
        if (baud_tick) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = fifo_empty ? IDLE : FETCH;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rd_en_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule : uart_tx_fifo_reader

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: two instances (1 and 2 stop bits), each fed
// by a small registered-read FIFO model. Frames are checked clock by clock
// against hand-computed bit patterns.
module tb_uart_tx_fifo_reader;
  import uart_pkg::*;

  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- FIFO models (registered read) ----------------
  logic [7:0] mem1 [0:63];
  logic [5:0] wr1 = '0, rd1 = '0;
  logic [7:0] fifo_data1 = '0;
  logic       fifo_empty1;
  logic [7:0] mem2 [0:63];
  logic [5:0] wr2 = '0, rd2 = '0;
  logic [7:0] fifo_data2 = '0;
  logic       fifo_empty2;

  assign fifo_empty1 = (wr1 == rd1);
  assign fifo_empty2 = (wr2 == rd2);

  logic fifo_rd_en1, tx1, busy1, tx_done1;
  logic fifo_rd_en2, tx2, busy2, tx_done2;

  always @(posedge clk) begin
    if (fifo_rd_en1 && (wr1 != rd1)) begin
      fifo_data1 <= mem1[rd1];
      rd1        <= rd1 + 6'd1;
    end
    if (fifo_rd_en2 && (wr2 != rd2)) begin
      fifo_data2 <= mem2[rd2];
      rd2        <= rd2 + 6'd1;
    end
  end

  // ---------------- DUTs ----------------
  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty1),
    .fifo_data  (fifo_data1),
    .fifo_rd_en (fifo_rd_en1),
    .tx         (tx1),
    .busy       (busy1),
    .tx_done    (tx_done1)
  );

  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty2),
    .fifo_data  (fifo_data2),
    .fifo_rd_en (fifo_rd_en2),
    .tx         (tx2),
    .busy       (busy2),
    .tx_done    (tx_done2)
  );

  // Monitor mux: sel=0 watches dut, sel=1 watches dut2.
  logic sel = 1'b0;
  wire  m_tx   = sel ? tx2 : tx1;
  wire  m_busy = sel ? busy2 : busy1;
  wire  m_done = sel ? tx_done2 : tx_done1;

  // ---------------- event counters (sampled on negedge) ----------------
  int rd_pulses1 = 0, done_pulses1 = 0, viol1 = 0;
  int rd_pulses2 = 0, done_pulses2 = 0, viol2 = 0;
  always @(negedge clk) begin
    if (fifo_rd_en1) rd_pulses1++;
    if (tx_done1) done_pulses1++;
    if (fifo_rd_en1 && fifo_empty1) viol1++;
    if (fifo_rd_en2) rd_pulses2++;
    if (tx_done2) done_pulses2++;
    if (fifo_rd_en2 && fifo_empty2) viol2++;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push1(input logic [7:0] b);
    mem1[wr1] = b;
    wr1 = wr1 + 6'd1;
  endtask

  task automatic push2(input logic [7:0] b);
    mem2[wr2] = b;
    wr2 = wr2 + 6'd1;
  endtask

  // Advance negedges until the watched tx is low; bounded at 50 clocks.
  task automatic wait_tx_low(output int lat);
    lat = 0;
    while ((m_tx !== 1'b0) && (lat < 50)) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] bits;   // bits[i] = i-th transmitted bit (start first)
    int          nbits;  // total bit times in the frame
  } vec_t;

  vec_t tab [6];

  // Entered on the first tx=0 clock; checks every clock of the frame, then
  // steps to the clock after the last stop cycle and checks tx_done there.
  task automatic run_frame(input vec_t v, input bit more, input string nm);
    logic [7:0] dec;
    dec = '0;
    for (int i = 0; i < v.nbits * CPB; i++) begin
      if (i > 0) @(negedge clk);
      check({nm, "_tx"}, 32'(m_tx), 32'(v.bits[i / CPB]));
      check({nm, "_busy"}, 32'(m_busy), 32'd1);
      check({nm, "_done_early"}, 32'(m_done), 32'd0);
      if ((i % CPB == 2) && (i / CPB >= 1) && (i / CPB <= 8)) dec[i / CPB - 1] = m_tx;
    end
    @(negedge clk);
    check({nm, "_done"}, 32'(m_done), 32'd1);
    check({nm, "_busy_end"}, 32'(m_busy), 32'(more));
    check({nm, "_tx_end"}, 32'(m_tx), 32'd1);
    check({nm, "_decoded"}, 32'(dec), 32'(v.data));
  endtask

  task automatic check_quiet(input string nm);
    @(negedge clk);
    check({nm, "_done_clr"}, 32'(m_done), 32'd0);
    check({nm, "_busy_clr"}, 32'(m_busy), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int bad;
    int done_before;

    // Frames written as {stop(s), data[7:0], start}.
    tab[0] = '{8'hA5, 11'b01101001010, 10};
    tab[1] = '{8'h3C, 11'b01001111000, 10};
    tab[2] = '{8'h81, 11'b01100000010, 10};
    tab[3] = '{8'h00, 11'b01000000000, 10};
    tab[4] = '{8'hFF, 11'b01111111110, 10};
    tab[5] = '{8'h55, 11'b11010101010, 11};

    // Reset held 3 clocks with empty FIFOs.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx1), 32'd1);
    check("rst_rd_en", 32'(fifo_rd_en1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(tx_done1), 32'd0);
    check("rst2_tx", 32'(tx2), 32'd1);
    check("rst2_busy", 32'(busy2), 32'd0);

    // Empty FIFO for 200 clocks: nothing happens.
    reset = 1'b0;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || fifo_rd_en1 !== 1'b0 || busy1 !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    check("idle_rd_pulses", 32'(rd_pulses1), 32'd0);

    // Single-byte frames from the table.
    for (int k = 0; k < 5; k++) begin
      push1(tab[k].data);
      wait_tx_low(lat);
      check($sformatf("v%0d_latency", k), 32'(lat), 32'd3);
      run_frame(tab[k], 1'b0, $sformatf("v%0d", k));
      check_quiet($sformatf("v%0d", k));
      check($sformatf("v%0d_rd_pulses", k), 32'(rd_pulses1), 32'(k + 1));
    end

    // Back-to-back 0x00 then 0xFF: two idle-high clocks between frames.
    push1(8'h00);
    push1(8'hFF);
    wait_tx_low(lat);
    check("b2b_latency", 32'(lat), 32'd3);
    run_frame(tab[3], 1'b1, "b2b_a");
    wait_tx_low(lat);
    check("b2b_gap", 32'(lat), 32'd2);
    run_frame(tab[4], 1'b0, "b2b_b");
    check_quiet("b2b");
    check("b2b_rd_pulses", 32'(rd_pulses1), 32'd7);

    // Reset during data bit 3 of the 0x3C frame; 0x81 follows intact.
    push1(8'h3C);
    push1(8'h81);
    wait_tx_low(lat);
    check("abort_latency", 32'(lat), 32'd3);
    repeat (17) @(negedge clk);
    check("abort_bit3", 32'(tx1), 32'd1);
    done_before = done_pulses1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(tx1), 32'd1);
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_done", 32'(tx_done1), 32'd0);
    @(negedge clk);
    check("abort_rd_en", 32'(fifo_rd_en1), 32'd0);
    reset = 1'b0;
    check("abort_no_done", 32'(done_pulses1), 32'(done_before));
    wait_tx_low(lat);
    check("resume_latency", 32'(lat), 32'd3);
    run_frame(tab[2], 1'b0, "resume");
    check_quiet("resume");
    check("resume_rd_pulses", 32'(rd_pulses1), 32'd9);
    check("total_done1", 32'(done_pulses1), 32'd8);
    check("fifo1_drained", 32'(fifo_empty1), 32'd1);

    // Two stop bits: 0x55 frame is 44 clocks, last 8 high.
    sel = 1'b1;
    push2(8'h55);
    wait_tx_low(lat);
    check("stop2_latency", 32'(lat), 32'd3);
    run_frame(tab[5], 1'b0, "stop2");
    check_quiet("stop2");
    check("stop2_rd_pulses", 32'(rd_pulses2), 32'd1);
    check("stop2_done_pulses", 32'(done_pulses2), 32'd1);

    check("rd_while_empty1", 32'(viol1), 32'd0);
    check("rd_while_empty2", 32'(viol2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_fifo_reader
